lsu_msq: RTL and testbench
==========================

LSU_MSQ -- requirements
Module: lsu_msq

Interface
REQ-001 SHALL have parameter MSQ_DEPTH, default 4: number of miss entries (power of 2, >=2).
REQ-002 SHALL have parameter DC_LINE_SIZE, default 16: cache line bytes; the line is 128 bits at default.
REQ-003 SHALL have ports in this order:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have store-retire ports (from SQ):
- i_sq_retire_data  in  32  store data; low bytes used.
- i_sq_retire_addr  in  32  store byte address.
- i_sq_retire_lsu_func  in  procyon_lsu_func_t  SB/SH/SW.
- i_sq_retire_en  in  1  retire valid.
- i_sq_retire_dc_hit  in  1  D$ hit; the MSQ ignores hits.
- o_msq_full  out  1  cannot accept this store (drives SQ i_sq_retire_msq_full).
REQ-005 SHALL have memory request ports:
- o_mem_req_valid  out  1
- o_mem_req_addr  out  32  line-aligned.
- o_mem_req_id  out  log2(MSQ_DEPTH)  entry index.
- i_mem_req_ready  in  1
REQ-006 SHALL have memory fill response ports:
- i_mem_rsp_valid  in  1
- i_mem_rsp_id  in  log2(MSQ_DEPTH)
- i_mem_rsp_data  in  DC_LINE_SIZE*8
REQ-007 SHALL have D$ fill ports:
- o_dc_fill_valid  out  1
- o_dc_fill_addr  out  32
- o_dc_fill_data  out  DC_LINE_SIZE*8
- i_dc_fill_ready  in  1

Function
REQ-008 Each entry SHALL hold a state (IDLE, PENDING, ISSUED, FILL), a line address, a line data register and a byte mask.
REQ-009 An enqueue SHALL occur when i_sq_retire_en && ~i_sq_retire_dc_hit && ~o_msq_full.
REQ-010 Byte lanes SHALL be written as follows, with offset = addr[log2(DC_LINE_SIZE)-1:0]:
- SB writes 1 byte.
- SH writes 2 bytes.
- SW writes 4 bytes.
- Misaligned SH/SW is undefined.
REQ-011 Merge: an enqueue whose line matches a PENDING or ISSUED entry SHALL write its bytes and set its mask bits in that entry; later data overwrites earlier data.
REQ-012 Allocate: an enqueue with no merge target SHALL take the lowest-index IDLE entry, load its line address, and set that entry's mask to only the store bytes; the entry goes IDLE->PENDING.
REQ-013 o_msq_full SHALL be combinational and set when either condition holds:
- the retire line matches a FILL entry; or
- there is no merge target and no IDLE entry.
REQ-014 Request: the lowest-index PENDING entry SHALL drive o_mem_req_*; on valid&&ready the entry goes PENDING->ISSUED.
REQ-015 A request SHALL NOT be issued in the same cycle the entry is allocated; the earliest o_mem_req_valid is the cycle after enqueue.
REQ-016 Response: i_mem_rsp_valid for an ISSUED entry SHALL produce a merged line register value and move the entry ISSUED->FILL; the merged line is rsp bytes where mask=0 and entry bytes where mask=1.
REQ-017 A response whose id is not ISSUED SHALL be ignored.
REQ-018 A store merge and a response to the same entry in the same cycle SHALL both apply, and the store bytes SHALL win.
REQ-019 Fill: the lowest-index FILL entry SHALL drive o_dc_fill_*, starting from the cycle after the response.
REQ-020 On o_dc_fill_valid&&i_dc_fill_ready the entry SHALL go FILL->IDLE and clear its mask.
REQ-021 An entry SHALL be reusable for allocation the cycle after it goes IDLE.
REQ-022 The block SHALL have no flush input; retired stores are never dropped.

Reset
REQ-023 On rst: all entries IDLE, masks 0, o_mem_req_valid=0, o_dc_fill_valid=0, o_msq_full=0.
REQ-024 Reset mid-operation SHALL abandon all entries.
REQ-025 Responses arriving after reset SHALL be ignored (REQ-017).

Configuration
REQ-026 With MSQ_MERGE_EN defined, merging SHALL operate per REQ-011.
REQ-027 Without MSQ_MERGE_EN, any line match with a non-IDLE entry SHALL assert o_msq_full, and every enqueue allocates a new entry.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- SW 0xDEADBEEF @0x1004, miss -> entry0 PENDING; next cycle req addr 0x1000 id 0; rsp all-0x11 -> fill line bytes 4..7 = EF BE AD DE, other bytes 0x11.
- SB 0xAA @0x2003, then SB 0xBB @0x2003 while ISSUED (merge on) -> single request; fill byte3 = 0xBB.
- Fill 4 entries with distinct lines, i_mem_req_ready=0 -> o_msq_full=1 on 5th miss, SQ stall held; after one fill completes -> full drops the following cycle.
- Response and SH 0x1234 @0x3002 to the same ISSUED entry in the same cycle -> fill bytes 2..3 = 34 12.
- Store to a line in FILL with i_dc_fill_ready=0 -> o_msq_full=1 until fill accepted.
- rst asserted with 2 entries ISSUED, then rsp id 0 -> no o_dc_fill_valid; with MSQ_MERGE_EN undefined, second store to same line -> o_msq_full=1.

Source files
------------

// File: rtl/procyon_pkg.sv
// rtl/procyon_pkg.sv - shared LSU operation encodings
package procyon_pkg;

  typedef enum logic [1:0] {
    LSU_FUNC_SB   = 2'd0,
    LSU_FUNC_SH   = 2'd1,
    LSU_FUNC_SW   = 2'd2,
    LSU_FUNC_NONE = 2'd3
  } procyon_lsu_func_t;

endpackage

// File: rtl/lsu_msq.sv
// rtl/lsu_msq.sv - store miss queue: holds retired store misses, fetches their lines, fills the D$
// Define MSQ_MERGE_EN to let a store merge into an in-flight entry for the same line.
module lsu_msq
  import procyon_pkg::*;
#(
  parameter int MSQ_DEPTH    = 4,
  parameter int DC_LINE_SIZE = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  i_sq_retire_data,
  input  logic [31:0]                  i_sq_retire_addr,
  input  procyon_lsu_func_t            i_sq_retire_lsu_func,
  input  logic                         i_sq_retire_en,
  input  logic                         i_sq_retire_dc_hit,
  output logic                         o_msq_full,
  output logic                         o_mem_req_valid,
  output logic [31:0]                  o_mem_req_addr,
  output logic [$clog2(MSQ_DEPTH)-1:0] o_mem_req_id,
  input  logic                         i_mem_req_ready,
  input  logic                         i_mem_rsp_valid,
  input  logic [$clog2(MSQ_DEPTH)-1:0] i_mem_rsp_id,
  input  logic [DC_LINE_SIZE*8-1:0]    i_mem_rsp_data,
  output logic                         o_dc_fill_valid,
  output logic [31:0]                  o_dc_fill_addr,
  output logic [DC_LINE_SIZE*8-1:0]    o_dc_fill_data,
  input  logic                         i_dc_fill_ready
);
  localparam int ID_W   = $clog2(MSQ_DEPTH);
  localparam int OFF_W  = $clog2(DC_LINE_SIZE);
  localparam int TAG_W  = 32 - OFF_W;
  localparam int LINE_W = DC_LINE_SIZE * 8;

  typedef enum logic [1:0] {MSQ_IDLE, MSQ_PENDING, MSQ_ISSUED, MSQ_FILL} msq_state_t;

  msq_state_t              r_state      [MSQ_DEPTH];
  msq_state_t              w_state_next [MSQ_DEPTH];
  logic [TAG_W-1:0]        r_tag        [MSQ_DEPTH];
  logic [LINE_W-1:0]       r_data       [MSQ_DEPTH];
  logic [DC_LINE_SIZE-1:0] r_mask       [MSQ_DEPTH];

  logic [TAG_W-1:0]        w_tag;
  logic [OFF_W-1:0]        w_off;
  logic [DC_LINE_SIZE-1:0] w_st_mask;
  logic [LINE_W-1:0]       w_st_data;
  logic [MSQ_DEPTH-1:0]    w_match;
  logic                    w_match_fill;
  logic                    w_idle_hit, w_req_hit, w_fill_hit, w_merge_hit;
  logic [ID_W-1:0]         w_idle_idx, w_req_idx, w_fill_idx, w_merge_idx;
  logic                    w_full, w_enq;
  logic [MSQ_DEPTH-1:0]    w_alloc_sel, w_merge_sel, w_issue_sel, w_rsp_sel, w_done_sel;

  assign w_tag = i_sq_retire_addr[31:OFF_W];
  assign w_off = i_sq_retire_addr[OFF_W-1:0];

  always_comb begin
    w_st_mask = '0;
    case (i_sq_retire_lsu_func)
      LSU_FUNC_SB: w_st_mask = {{(DC_LINE_SIZE-1){1'b0}}, 1'b1} << w_off;
      LSU_FUNC_SH: w_st_mask = {{(DC_LINE_SIZE-2){1'b0}}, 2'b11} << w_off;
      LSU_FUNC_SW: w_st_mask = {{(DC_LINE_SIZE-4){1'b0}}, 4'hF} << w_off;
      default:     w_st_mask = '0;
    endcase
  end

  assign w_st_data = {{(LINE_W-32){1'b0}}, i_sq_retire_data} << {w_off, 3'b000};

  // Descending scan so the lowest-index candidate is the one left standing.
  always_comb begin
    w_match      = '0;
    w_match_fill = 1'b0;
    w_idle_hit   = 1'b0;
    w_idle_idx   = '0;
    w_req_hit    = 1'b0;
    w_req_idx    = '0;
    w_fill_hit   = 1'b0;
    w_fill_idx   = '0;
    for (int i = MSQ_DEPTH-1; i >= 0; i--) begin
      w_match[i] = (r_tag[i] == w_tag);
      if (r_state[i] == MSQ_IDLE) begin
        w_idle_hit = 1'b1;
        w_idle_idx = ID_W'(i);
      end
      if (r_state[i] == MSQ_PENDING) begin
        w_req_hit = 1'b1;
        w_req_idx = ID_W'(i);
      end
      if (r_state[i] == MSQ_FILL) begin
        w_fill_hit = 1'b1;
        w_fill_idx = ID_W'(i);
        if (r_tag[i] == w_tag) w_match_fill = 1'b1;
      end
    end
  end

`ifdef MSQ_MERGE_EN
  always_comb begin
    w_merge_hit = 1'b0;
    w_merge_idx = '0;
    for (int i = MSQ_DEPTH-1; i >= 0; i--) begin
      if (w_match[i] && (r_state[i] == MSQ_PENDING || r_state[i] == MSQ_ISSUED)) begin
        w_merge_hit = 1'b1;
        w_merge_idx = ID_W'(i);
      end
    end
  end
  assign w_full = w_match_fill | (~w_merge_hit & ~w_idle_hit);
`else
  logic w_match_busy;
  always_comb begin
    w_match_busy = 1'b0;
    for (int i = 0; i < MSQ_DEPTH; i++) begin
      if (w_match[i] && r_state[i] != MSQ_IDLE) w_match_busy = 1'b1;
    end
  end
  assign w_merge_hit = 1'b0;
  assign w_merge_idx = '0;
  assign w_full      = w_match_busy | w_match_fill | ~w_idle_hit;
`endif

  assign o_msq_full      = w_full & ~rst;
  assign w_enq           = i_sq_retire_en & ~i_sq_retire_dc_hit & ~o_msq_full;
  assign o_mem_req_valid = w_req_hit & ~rst;
  assign o_mem_req_addr  = {r_tag[w_req_idx], {OFF_W{1'b0}}};
  assign o_mem_req_id    = w_req_idx;
  assign o_dc_fill_valid = w_fill_hit & ~rst;
  assign o_dc_fill_addr  = {r_tag[w_fill_idx], {OFF_W{1'b0}}};
  assign o_dc_fill_data  = r_data[w_fill_idx];

  always_comb begin
    for (int i = 0; i < MSQ_DEPTH; i++) begin
      w_alloc_sel[i] = w_enq & ~w_merge_hit & (w_idle_idx == ID_W'(i));
      w_merge_sel[i] = w_enq & w_merge_hit & (w_merge_idx == ID_W'(i));
      w_issue_sel[i] = o_mem_req_valid & i_mem_req_ready & (w_req_idx == ID_W'(i));
      w_rsp_sel[i]   = i_mem_rsp_valid & (i_mem_rsp_id == ID_W'(i)) & (r_state[i] == MSQ_ISSUED);
      w_done_sel[i]  = o_dc_fill_valid & i_dc_fill_ready & (w_fill_idx == ID_W'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < MSQ_DEPTH; i++) begin
      w_state_next[i] = r_state[i];
      if (w_alloc_sel[i]) w_state_next[i] = MSQ_PENDING;
      if (w_issue_sel[i]) w_state_next[i] = MSQ_ISSUED;
      if (w_rsp_sel[i])   w_state_next[i] = MSQ_FILL;
      if (w_done_sel[i])  w_state_next[i] = MSQ_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < MSQ_DEPTH; i++) begin
      if (rst) r_state[i] <= MSQ_IDLE;
      else     r_state[i] <= w_state_next[i];
    end
  end

  // Store bytes take priority over response bytes; the mask shields earlier stores from the fetched line.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MSQ_DEPTH; i++) begin
      if (rst) begin
        r_mask[i] <= '0;
      end else begin
        if (w_alloc_sel[i]) r_tag[i] <= w_tag;
        if (w_done_sel[i])       r_mask[i] <= '0;
        else if (w_alloc_sel[i]) r_mask[i] <= w_st_mask;
        else if (w_merge_sel[i]) r_mask[i] <= r_mask[i] | w_st_mask;
        for (int b = 0; b < DC_LINE_SIZE; b++) begin
          if ((w_alloc_sel[i] || w_merge_sel[i]) && w_st_mask[b])
            r_data[i][b*8 +: 8] <= w_st_data[b*8 +: 8];
          else if (w_rsp_sel[i] && !r_mask[i][b])
            r_data[i][b*8 +: 8] <= i_mem_rsp_data[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_msq.sv
// tb/tb_lsu_msq.sv - scoreboard bench for lsu_msq; expectations follow MSQ_MERGE_EN
module tb_lsu_msq;
  import procyon_pkg::*;

  localparam int LW = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       i_sq_retire_data, i_sq_retire_addr;
  procyon_lsu_func_t i_sq_retire_lsu_func;
  logic              i_sq_retire_en, i_sq_retire_dc_hit;
  logic              o_msq_full;
  logic              o_mem_req_valid;
  logic [31:0]       o_mem_req_addr;
  logic [1:0]        o_mem_req_id;
  logic              i_mem_req_ready;
  logic              i_mem_rsp_valid;
  logic [1:0]        i_mem_rsp_id;
  logic [LW-1:0]     i_mem_rsp_data;
  logic              o_dc_fill_valid;
  logic [31:0]       o_dc_fill_addr;
  logic [LW-1:0]     o_dc_fill_data;
  logic              i_dc_fill_ready;

  always #5 clk = ~clk;

  lsu_msq #(.MSQ_DEPTH(4), .DC_LINE_SIZE(16)) dut (
    .clk(clk), .rst(rst),
    .i_sq_retire_data(i_sq_retire_data), .i_sq_retire_addr(i_sq_retire_addr),
    .i_sq_retire_lsu_func(i_sq_retire_lsu_func), .i_sq_retire_en(i_sq_retire_en),
    .i_sq_retire_dc_hit(i_sq_retire_dc_hit), .o_msq_full(o_msq_full),
    .o_mem_req_valid(o_mem_req_valid), .o_mem_req_addr(o_mem_req_addr),
    .o_mem_req_id(o_mem_req_id), .i_mem_req_ready(i_mem_req_ready),
    .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_id(i_mem_rsp_id),
    .i_mem_rsp_data(i_mem_rsp_data),
    .o_dc_fill_valid(o_dc_fill_valid), .o_dc_fill_addr(o_dc_fill_addr),
    .o_dc_fill_data(o_dc_fill_data), .i_dc_fill_ready(i_dc_fill_ready)
  );

  typedef struct packed { logic [31:0] addr; logic [1:0] id; } req_t;
  typedef struct packed { logic [31:0] addr; logic [LW-1:0] data; } fill_t;

  req_t  q_req[$];
  fill_t q_fill[$];
  req_t  m_req;
  fill_t m_fill;
  int    n_cmp = 0;
  int    n_err = 0;
  logic [LW-1:0] exp_line;

  task automatic check_eq(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] splat(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic logic [LW-1:0] put(input logic [LW-1:0] line, input int off,
                                        input logic [31:0] d, input int n);
    logic [LW-1:0] l;
    l = line;
    for (int k = 0; k < n; k++) l[(off+k)*8 +: 8] = d[k*8 +: 8];
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input procyon_lsu_func_t f);
    i_sq_retire_addr     = a;
    i_sq_retire_data     = d;
    i_sq_retire_lsu_func = f;
    i_sq_retire_en       = 1'b1;
  endtask

  task automatic clr_store();
    i_sq_retire_en     = 1'b0;
    i_sq_retire_dc_hit = 1'b0;
  endtask

  task automatic exp_req(input logic [31:0] a, input logic [1:0] id);
    q_req.push_back('{addr: a, id: id});
  endtask

  task automatic exp_fill(input logic [31:0] a, input logic [LW-1:0] d);
    q_fill.push_back('{addr: a, data: d});
  endtask

  task automatic respond(input logic [1:0] id, input logic [LW-1:0] d);
    i_mem_rsp_valid = 1'b1;
    i_mem_rsp_id    = id;
    i_mem_rsp_data  = d;
    tick();
    i_mem_rsp_valid = 1'b0;
  endtask

  task automatic drain_req();
    int n = 0;
    while (q_req.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check_eq("req_drain", LW'(q_req.size()), '0);
  endtask

  task automatic drain_fill();
    int n = 0;
    while (q_fill.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check_eq("fill_drain", LW'(q_fill.size()), '0);
  endtask

  // Monitors: every handshake pops the scoreboard; anything unexpected is flagged.
  always @(negedge clk) begin
    if (o_mem_req_valid && i_mem_req_ready) begin
      if (q_req.size() == 0) check_eq("req_unexpected", LW'(o_mem_req_valid), '0);
      else begin
        m_req = q_req.pop_front();
        check_eq("req_addr", LW'(o_mem_req_addr), LW'(m_req.addr));
        check_eq("req_id", LW'(o_mem_req_id), LW'(m_req.id));
      end
    end
    if (o_dc_fill_valid && i_dc_fill_ready) begin
      if (q_fill.size() == 0) check_eq("fill_unexpected", LW'(o_dc_fill_valid), '0);
      else begin
        m_fill = q_fill.pop_front();
        check_eq("fill_addr", LW'(o_dc_fill_addr), LW'(m_fill.addr));
        check_eq("fill_data", o_dc_fill_data, m_fill.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_sq_retire_data = '0; i_sq_retire_addr = '0; i_sq_retire_lsu_func = LSU_FUNC_SW;
    i_sq_retire_en = 1'b0; i_sq_retire_dc_hit = 1'b0;
    i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_mem_rsp_id = '0; i_mem_rsp_data = '0;
    i_dc_fill_ready = 1'b1;
    repeat (3) tick();
    check_eq("rst_req_valid", LW'(o_mem_req_valid), '0);
    check_eq("rst_fill_valid", LW'(o_dc_fill_valid), '0);
    check_eq("rst_full", LW'(o_msq_full), '0);
    rst = 1'b0;
    tick();

    // D$ hits are not queued
    i_sq_retire_dc_hit = 1'b1;
    drive_store(32'h8000, 32'h12345678, LSU_FUNC_SW);
    tick();
    clr_store();
    #1 check_eq("hit_ignored", LW'(o_mem_req_valid), '0);

    // SW miss, request the cycle after enqueue, fill merges store over response
    drive_store(32'h1004, 32'hDEADBEEF, LSU_FUNC_SW);
    #1 check_eq("s1_full", LW'(o_msq_full), '0);
    check_eq("s1_req_early", LW'(o_mem_req_valid), '0);
    exp_req(32'h1000, 2'd0);
    tick();
    clr_store();
    #1 check_eq("s1_req_valid", LW'(o_mem_req_valid), 1);
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    exp_fill(32'h1000, put(splat(8'h11), 4, 32'hDEADBEEF, 4));
    i_mem_rsp_valid = 1'b1; i_mem_rsp_id = 2'd0; i_mem_rsp_data = splat(8'h11);
    #1 check_eq("s1_fill_early", LW'(o_dc_fill_valid), '0);
    tick();
    i_mem_rsp_valid = 1'b0;
    drain_fill();

    // Second SB to an ISSUED line
    i_mem_req_ready = 1'b1;
    drive_store(32'h2003, 32'h000000AA, LSU_FUNC_SB);
    exp_req(32'h2000, 2'd0);
    tick();
    clr_store();
    tick();
    tick();
    drive_store(32'h2003, 32'h000000BB, LSU_FUNC_SB);
`ifdef MSQ_MERGE_EN
    #1 check_eq("s2_merge_full", LW'(o_msq_full), '0);
    exp_line = put(splat(8'h00), 3, 32'hBB, 1);
`else
    #1 check_eq("s2_nomerge_full", LW'(o_msq_full), 1);
    exp_line = put(splat(8'h00), 3, 32'hAA, 1);
`endif
    tick();
    clr_store();
    exp_fill(32'h2000, exp_line);
    respond(2'd0, splat(8'h00));
    drain_fill();
    drain_req();

    // Response and SH to the same ISSUED entry in one cycle
    drive_store(32'h3000, 32'h00000055, LSU_FUNC_SB);
    exp_req(32'h3000, 2'd0);
    tick();
    clr_store();
    tick();
    tick();
    i_mem_rsp_valid = 1'b1; i_mem_rsp_id = 2'd0; i_mem_rsp_data = splat(8'h22);
    drive_store(32'h3002, 32'h00001234, LSU_FUNC_SH);
    exp_line = put(splat(8'h22), 0, 32'h55, 1);
`ifdef MSQ_MERGE_EN
    #1 check_eq("s4_full", LW'(o_msq_full), '0);
    exp_line = put(exp_line, 2, 32'h1234, 2);
`else
    #1 check_eq("s4_full", LW'(o_msq_full), 1);
`endif
    exp_fill(32'h3000, exp_line);
    tick();
    i_mem_rsp_valid = 1'b0;
    clr_store();
    drain_fill();

    // Four distinct lines with memory stalled; fifth miss is refused until a fill retires
    i_mem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_store(32'h4000 + 32'(16*k), 32'h10000000 + 32'(k), LSU_FUNC_SW);
      #1 check_eq("s3_full_k", LW'(o_msq_full), '0);
      exp_req(32'h4000 + 32'(16*k), 2'(k));
      tick();
    end
    drive_store(32'h4040, 32'hA5A5A5A5, LSU_FUNC_SW);
    for (int k = 0; k < 3; k++) begin
      #1 check_eq("s3_full_held", LW'(o_msq_full), 1);
      tick();
    end
    i_mem_req_ready = 1'b1;
    drain_req();
    i_mem_req_ready = 1'b0;
    i_dc_fill_ready = 1'b0;
    exp_fill(32'h4020, put(splat(8'h00), 0, 32'h10000002, 4));
    respond(2'd2, splat(8'h00));
    #1 check_eq("s3_full_in_fill", LW'(o_msq_full), 1);
    check_eq("s3_fill_valid", LW'(o_dc_fill_valid), 1);
    i_dc_fill_ready = 1'b1;
    tick();
    #1 check_eq("s3_full_drop", LW'(o_msq_full), '0);
    exp_req(32'h4040, 2'd2);
    tick();
    clr_store();
    i_mem_req_ready = 1'b1;
    drain_req();
    for (int k = 0; k < 4; k++) begin
      int id;
      id = (k == 2) ? 3 : (k == 3) ? 2 : k;
      if (id == 2) exp_fill(32'h4040, put(splat(8'h00), 0, 32'hA5A5A5A5, 4));
      else         exp_fill(32'h4000 + 32'(16*id), put(splat(8'h00), 0, 32'h10000000 + 32'(id), 4));
      respond(2'(id), splat(8'h00));
      drain_fill();
    end

    // Store to a line sitting in FILL while the D$ stalls
    i_dc_fill_ready = 1'b0;
    drive_store(32'h5000, 32'h00000001, LSU_FUNC_SB);
    exp_req(32'h5000, 2'd0);
    tick();
    clr_store();
    tick();
    exp_fill(32'h5000, put(splat(8'h00), 0, 32'h01, 1));
    respond(2'd0, splat(8'h00));
    drive_store(32'h5008, 32'hCAFEF00D, LSU_FUNC_SW);
    for (int k = 0; k < 3; k++) begin
      #1 check_eq("s5_full_fill", LW'(o_msq_full), 1);
      tick();
    end
    i_dc_fill_ready = 1'b1;
    tick();
    #1 check_eq("s5_full_drop", LW'(o_msq_full), '0);
    exp_req(32'h5000, 2'd0);
    tick();
    clr_store();
    tick();
    exp_fill(32'h5000, put(splat(8'h33), 8, 32'hCAFEF00D, 4));
    respond(2'd0, splat(8'h33));
    drain_fill();

    // Reset with two entries ISSUED abandons them; late response is ignored
    drive_store(32'h6000, 32'h1, LSU_FUNC_SW);
    exp_req(32'h6000, 2'd0);
    tick();
    drive_store(32'h6010, 32'h2, LSU_FUNC_SW);
    exp_req(32'h6010, 2'd1);
    tick();
    clr_store();
    drain_req();
    rst = 1'b1;
    #1 check_eq("s6_rst_req", LW'(o_mem_req_valid), '0);
    check_eq("s6_rst_fill", LW'(o_dc_fill_valid), '0);
    tick();
    tick();
    rst = 1'b0;
    #1 check_eq("s6_post_full", LW'(o_msq_full), '0);
    respond(2'd0, splat(8'h44));
    for (int k = 0; k < 4; k++) begin
      #1 check_eq("s6_fill_after_rst", LW'(o_dc_fill_valid), '0);
      tick();
    end

    // Second store to the same line
    i_mem_req_ready = 1'b0;
    drive_store(32'h7000, 32'h1, LSU_FUNC_SW);
    #1 check_eq("s6_first_full", LW'(o_msq_full), '0);
    exp_req(32'h7000, 2'd0);
    tick();
    drive_store(32'h7004, 32'h2, LSU_FUNC_SW);
    exp_line = put(splat(8'h00), 0, 32'h1, 4);
`ifdef MSQ_MERGE_EN
    #1 check_eq("s6_second_full", LW'(o_msq_full), '0);
    exp_line = put(exp_line, 4, 32'h2, 4);
`else
    #1 check_eq("s6_second_full", LW'(o_msq_full), 1);
`endif
    tick();
    clr_store();
    i_mem_req_ready = 1'b1;
    drain_req();
    exp_fill(32'h7000, exp_line);
    respond(2'd0, splat(8'h00));
    drain_fill();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
